// File: rtl/reg_arb_pkg.sv
// Shared constants for the register-file writeback arbiter: width defaults and port IDs.
package reg_arb_pkg;
    localparam int DATA_W_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT = 3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register: capture loads it, drain empties it, capture wins on a tie.
module wb_slot #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              capture,
    input  logic              drain,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (capture) begin
            valid_reg <= 1'b1;
            addr_reg  <= addr_d;
            data_reg  <= data_d;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign addr  = addr_reg;
    assign data  = data_reg;
endmodule

// File: rtl/reg_write_arbiter.sv
// Two-port (ALU / load) register-file write arbiter issuing writes oldest-first, one per cycle.
// Define REG_ARB_COALESCE_EN to merge two pending writes to the same register into the younger one.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_A,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [DATA_W-1:0] DATA_A,
    output logic              READY_A,
    input  logic              REQ_B,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] DATA_B,
    output logic              READY_B,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic [1:0]        PENDING
);
    logic [1:0]        req;
    logic [1:0]        valid;
    logic [1:0]        ready;
    logic [1:0]        cap;
    logic [1:0]        sel;
    logic [1:0]        drain;
    logic [ADDR_W-1:0] addr_in   [2];
    logic [DATA_W-1:0] data_in   [2];
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];

    logic              older_reg;
    logic              win;
    logic              coalesce;
    logic              write_reg;
    logic [ADDR_W-1:0] inaddress_reg;
    logic [DATA_W-1:0] in_reg;

    assign req              = {REQ_B, REQ_A};
    assign addr_in[PORT_A]  = ADDR_A;
    assign addr_in[PORT_B]  = ADDR_B;
    assign data_in[PORT_A]  = DATA_A;
    assign data_in[PORT_B]  = DATA_B;

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        wb_slot #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_slot (
            .CLK     (CLK),
            .RESET   (RESET),
            .capture (cap[gi]),
            .drain   (drain[gi]),
            .addr_d  (addr_in[gi]),
            .data_d  (data_in[gi]),
            .valid   (valid[gi]),
            .addr    (slot_addr[gi]),
            .data    (slot_data[gi])
        );
    end

    // Selection looks only at slot state, so READY never depends on REQ.
    always_comb begin
        sel      = valid;
        win      = valid[PORT_B] ? PORT_B : PORT_A;
        coalesce = 1'b0;
        if (&valid) begin
            sel            = 2'b00;
            sel[older_reg] = 1'b1;
            win            = older_reg;
`ifdef REG_ARB_COALESCE_EN
            if (slot_addr[PORT_A] == slot_addr[PORT_B]) begin
                coalesce = 1'b1;
                win      = ~older_reg;
            end
`endif
        end
    end

    assign drain = coalesce ? 2'b11 : sel;
    assign ready = ~valid | drain;
    assign cap   = req & ready;

    // A newly captured entry is always younger than a slot that stays valid across the edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            older_reg <= PORT_A;
        end else if (&cap) begin
            older_reg <= PORT_A;
        end else if (cap[PORT_A]) begin
            older_reg <= (valid[PORT_B] && !drain[PORT_B]) ? PORT_B : PORT_A;
        end else if (cap[PORT_B]) begin
            older_reg <= (valid[PORT_A] && !drain[PORT_A]) ? PORT_A : PORT_B;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            write_reg     <= 1'b0;
            inaddress_reg <= '0;
            in_reg        <= '0;
        end else if (|valid) begin
            write_reg     <= 1'b1;
            inaddress_reg <= slot_addr[win];
            in_reg        <= slot_data[win];
        end else begin
            write_reg     <= 1'b0;
        end
    end

    assign READY_A   = ready[PORT_A];
    assign READY_B   = ready[PORT_B];
    assign WRITE     = write_reg;
    assign INADDRESS = inaddress_reg;
    assign IN        = in_reg;
    assign PENDING   = valid;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a pending-list model predicts writes, a monitor checks them.
module tb_reg_write_arbiter;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_A = 1'b0, REQ_B = 1'b0;
    logic [2:0] ADDR_A = '0, ADDR_B = '0;
    logic [7:0] DATA_A = '0, DATA_B = '0;
    logic       READY_A, READY_B, WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;
    logic [1:0] PENDING;

    reg_write_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A), .READY_A(READY_A),
        .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .READY_B(READY_B),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic port; logic [2:0] addr; logic [7:0] data; } ent_t;
    typedef struct { logic [2:0] addr; logic [7:0] data; int cyc; } exp_t;

    ent_t pend[$];     // writes accepted but not yet issued, oldest first
    exp_t exp_q[$];    // predicted register-file writes
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One cycle of stimulus: check handshake against the model, predict the write, drive inputs.
    task automatic step(input logic ra, input logic [2:0] aa, input logic [7:0] da,
                        input logic rb, input logic [2:0] ab, input logic [7:0] db);
        logic has_a, has_b, dr_a, dr_b, rdy_a, rdy_b, issued, merged;
        ent_t w;
        @(negedge CLK);
        has_a = 1'b0; has_b = 1'b0; dr_a = 1'b0; dr_b = 1'b0; issued = 1'b0; merged = 1'b0;
        w = '{1'b0, 3'd0, 8'd0};
        foreach (pend[i]) begin
            if (pend[i].port) has_b = 1'b1;
            else              has_a = 1'b1;
        end
`ifdef REG_ARB_COALESCE_EN
        if (pend.size() == 2 && pend[0].addr == pend[1].addr) begin
            w = pend[1];
            pend.delete();
            dr_a = 1'b1; dr_b = 1'b1; issued = 1'b1; merged = 1'b1;
        end
`endif
        if (!merged && pend.size() > 0) begin
            w = pend.pop_front();
            if (w.port) dr_b = 1'b1;
            else        dr_a = 1'b1;
            issued = 1'b1;
        end
        rdy_a = !has_a || dr_a;
        rdy_b = !has_b || dr_b;
        chk("ready_a", int'(READY_A), int'(rdy_a));
        chk("ready_b", int'(READY_B), int'(rdy_b));
        chk("pending", int'(PENDING), int'({has_b, has_a}));
        if (issued) exp_q.push_back('{w.addr, w.data, cyc + 1});
        REQ_A = ra; ADDR_A = aa; DATA_A = da;
        REQ_B = rb; ADDR_B = ab; DATA_B = db;
        if (ra && rdy_a) pend.push_back('{1'b0, aa, da});
        if (rb && rdy_b) pend.push_back('{1'b1, ab, db});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0);
    endtask

    // Assert reset between edges while traffic is pending; everything in flight is discarded.
    task automatic reset_mid();
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        REQ_A = 1'b1; ADDR_A = 3'd6; DATA_A = 8'hE1;
        REQ_B = 1'b1; ADDR_B = 3'd7; DATA_B = 8'hE2;
        #1;
        chk("rst_write", int'(WRITE), 0);
        chk("rst_pending", int'(PENDING), 0);
        chk("rst_inaddress", int'(INADDRESS), 0);
        chk("rst_in", int'(IN), 0);
        pend.delete();
        exp_q.delete();
        last_addr = '0;
        last_data = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        REQ_A = 1'b0; REQ_B = 1'b0;
    endtask

    // Monitor: every cycle either matches the next predicted write or holds the last one.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (WRITE) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_write: got addr=%0d data=%h at cycle %0d, required no write",
                             INADDRESS, IN, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("write cycle=%0d addr=%0d data=%h", cyc, INADDRESS, IN);
                    if (INADDRESS !== e.addr || IN !== e.data || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                                 INADDRESS, IN, cyc, e.addr, e.data, e.cyc);
                    end
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                n_cmp++;
                if (INADDRESS !== last_addr || IN !== last_data) begin
                    n_bad++;
                    $display("FAIL hold: got addr=%0d data=%h, required addr=%0d data=%h",
                             INADDRESS, IN, last_addr, last_data);
                end
                if (exp_q.size() > 0) begin
                    n_cmp++;
                    if (exp_q[0].cyc <= cyc) begin
                        n_bad++;
                        $display("FAIL missed_write: got none at cycle %0d, required addr=%0d data=%h",
                                 cyc, exp_q[0].addr, exp_q[0].data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1;
        chk("init_write", int'(WRITE), 0);
        chk("init_pending", int'(PENDING), 0);
        chk("init_inaddress", int'(INADDRESS), 0);
        chk("init_in", int'(IN), 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // lone request
        step(1'b1, 3'd3, 8'h2A, 1'b0, 3'd0, 8'h00);
        idle(3);
        // simultaneous requests, A older
        step(1'b1, 3'd1, 8'h05, 1'b1, 3'd2, 8'h07);
        idle(3);
        // B(4,11) left waiting behind an older A, then A refilled with (4,22)
        step(1'b1, 3'd5, 8'h33, 1'b1, 3'd4, 8'h11);
        step(1'b1, 3'd4, 8'h22, 1'b0, 3'd0, 8'h00);
        idle(4);
        // back-to-back on port A
        for (int i = 1; i <= 4; i++) step(1'b1, 3'(i), 8'(i), 1'b0, 3'd0, 8'h00);
        idle(3);
        // reset with both slots occupied
        step(1'b1, 3'd1, 8'hA1, 1'b1, 3'd2, 8'hB2);
        reset_mid();
        step(1'b1, 3'd2, 8'h9C, 1'b0, 3'd0, 8'h00);
        idle(3);

        // randomized traffic with a small address space to provoke equal addresses
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 8'($urandom),
                 $urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 8'($urandom));
            if (i == 200) reset_mid();
        end
        idle(5);

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 3, SHALL set the register address width (2**ADDR_W registers).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 REQ_A  input  1  SHALL be the ALU writeback request.
REQ-006 ADDR_A  input  ADDR_W  SHALL be the ALU destination register.
REQ-007 DATA_A  input  DATA_W  SHALL be the ALU result.
REQ-008 READY_A  output  1  SHALL be high when slot A can accept a request this cycle.
REQ-009 REQ_B, ADDR_B, DATA_B, READY_B SHALL be the memory-load writeback port, identical to port A.
REQ-010 WRITE  output  1  SHALL be the register-file write enable.
REQ-011 INADDRESS  output  ADDR_W  SHALL be the register-file write address.
REQ-012 IN  output  DATA_W  SHALL be the register-file write data.
REQ-013 PENDING  output  2  SHALL report slot valid bits {B,A}.

Function
REQ-014 Each port SHALL own a one-entry slot; a transfer SHALL occur on a posedge where REQ_x && READY_x, capturing ADDR_x/DATA_x.
REQ-015 READY_x SHALL equal !VALID_x || SEL_x (the slot drains this edge); it SHALL NOT depend on REQ_x.
REQ-016 Selection SHALL be combinational from slot state only: one valid slot selects it; both valid selects the older; if both were captured on the same edge, A SHALL be older.
REQ-017 On each posedge with a slot selected, WRITE SHALL go to 1 and INADDRESS/IN SHALL load the selected slot, which clears unless refilled on the same edge.
REQ-018 With no slot selected, WRITE SHALL be 0 for that cycle; INADDRESS/IN SHALL hold.
REQ-019 Latency SHALL be exactly one cycle from capture edge to WRITE-asserted edge for a lone request, and at most two cycles when the other slot is older.
REQ-020 Writes SHALL reach the register file in capture order; no write SHALL be dropped or duplicated.
REQ-021 A refill of a draining slot SHALL be younger than the other valid slot.
REQ-022 Sustained throughput SHALL be one write per cycle; each port SHALL sustain at least one write per two cycles under contention.

Reset
REQ-023 RESET SHALL immediately clear both slots, set WRITE=0, INADDRESS=0, IN=0, PENDING=0 and age to "A older".
REQ-024 Pending writes present at reset SHALL be discarded; requests presented during RESET SHALL be ignored.
REQ-025 The first transfer after RESET deasserts SHALL behave as after power-up.

Configuration
REQ-026 With REG_ARB_COALESCE_EN defined, when both slots are valid with equal addresses, the arbiter SHALL issue only the younger write and clear both slots on that edge.
REQ-027 Without REG_ARB_COALESCE_EN, both writes SHALL be issued in age order on consecutive cycles.

Structure
REQ-028 Package reg_arb_pkg SHALL hold DATA_W/ADDR_W defaults and port-ID constants PORT_A=0 and PORT_B=1.
REQ-029 Sub-module wb_slot (valid, address and data holding register with capture/drain controls) SHALL be instantiated once per port.

Verification
REQ-030 Lone request: REQ_A=1, ADDR_A=3, DATA_A=8'h2A for one cycle -> next cycle WRITE=1, INADDRESS=3, IN=8'h2A; then WRITE=0.
REQ-031 Simultaneous requests: A(1,8'h05) and B(2,8'h07) on the same edge -> WRITE (1,05), then (2,07) on consecutive cycles.
REQ-032 Age ordering: B(4,8'h11) one cycle before A(4,8'h22) while B is blocked -> (4,11) then (4,22); with REG_ARB_COALESCE_EN, only (4,22).
REQ-033 Back-to-back: REQ_A high for 4 cycles, data 1..4, addr 1..4 -> READY_A stays 1; four consecutive WRITE cycles, data 1..4 in order.
REQ-034 Reset mid-operation: both slots valid, RESET asserted between edges -> WRITE=0 and PENDING=0 immediately; no write of either value after release.
